nv_sequence_receiver: RTL and testbench

- Receive-side counterpart of the NV controller's serialized sequence transmitter.
- Deserializes the MSB-first serial pulse stream one bit per strobe and frames bytes after synchronizing on SEQ1.
- Tracks protocol progress SEQ1 (init, retries allowed) → SEQ2 (transmission) → SEQ3 (termination/success).
- Used as loopback checker and as the NV-side emulator in system benches and hardware self-test.

---
 rtl/nv_ctrl_pkg.sv | 22 ++
 rtl/nv_bit_deframer.sv | 45 ++++
 rtl/nv_sequence_receiver.sv | 168 ++++++++++++++++
 tb/tb_nv_sequence_receiver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_ctrl_pkg.sv
// Shared NV controller definitions: rx/tx status encodings, default sequence
// patterns and a small saturating-counter helper. The transmitter imports the
// same constants so the two ends can never disagree on the patterns.
package nv_ctrl_pkg;

    typedef enum logic [1:0] {
        RX_HUNT    = 2'b00,
        RX_SYNCED  = 2'b01,
        RX_PAYLOAD = 2'b10,
        RX_DONE    = 2'b11
    } rx_status_e;

    localparam logic [7:0] NV_SEQ1 = 8'hD7;
    localparam logic [7:0] NV_SEQ2 = 8'hA6;
    localparam logic [7:0] NV_SEQ3 = 8'h29;

    // 8-bit increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/nv_bit_deframer.sv
// Serial-to-parallel front end: MSB-first shift register plus the bit counter
// that marks byte boundaries once the receiver has framed on SEQ1.
// next_word is the value the shift register takes on this strobe, so the
// FSM can match on it in the same cycle the bit arrives.
module nv_bit_deframer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       serial_in,
    input  logic       shift_en,    // accepted strobe (already masked in DONE)
    input  logic       frame_en,    // counting bits into bytes (SYNCED/PAYLOAD)
    input  logic       frame_rst,   // force bit counter back to a byte boundary
    output logic [7:0] next_word,
    output logic       byte_done
);

    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q;

    assign next_word = {sr_q[6:0], serial_in};
    assign byte_done = shift_en && frame_en && (bit_cnt_q == 3'd7);

    // Shift register: keeps sliding in HUNT so SEQ1 can be found at any offset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= 8'h00;
        end else if (clear) begin
            sr_q <= 8'h00;
        end else if (shift_en) begin
            sr_q <= next_word;
        end
    end

    // Bit counter: wraps 7 -> 0 on byte completion, held at 0 outside framing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= 3'd0;
        end else if (clear || frame_rst) begin
            bit_cnt_q <= 3'd0;
        end else if (shift_en && frame_en) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/nv_sequence_receiver.sv
// NV sequence receiver: hunts for SEQ1 in the serial stream, then frames
// bytes and walks SEQ1 (repeats allowed) -> SEQ2 -> SEQ3. Any unexpected
// framed byte or an idle gap of TIMEOUT_CYCLES drops back to HUNT.
// Optional: define NV_SEQ_RX_ERR_COUNT_EN to add saturating err_count and
// to_count outputs tallying error and timeout pulses.
module nv_sequence_receiver
    import nv_ctrl_pkg::*;
#(
    parameter logic [7:0] SEQ1           = NV_SEQ1,
    parameter logic [7:0] SEQ2           = NV_SEQ2,
    parameter logic [7:0] SEQ3           = NV_SEQ3,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter int         TO_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       serial_valid,
    input  logic       clear,
    output logic [1:0] rx_status,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [7:0] seq1_count,
    output logic       error,
    output logic       timeout
`ifdef NV_SEQ_RX_ERR_COUNT_EN
    ,
    output logic [7:0] err_count,
    output logic [7:0] to_count
`endif
);

    rx_status_e      state_q;
    logic [7:0]      byte_out_q;
    logic            byte_valid_q;
    logic [7:0]      seq1_count_q;
    logic            error_q;
    logic            timeout_q;
    logic [TO_W-1:0] idle_q;

    logic       in_frame;
    logic       shift_en;
    logic       byte_done;
    logic       timeout_evt;
    logic [7:0] next_word;

    assign in_frame = (state_q == RX_SYNCED) || (state_q == RX_PAYLOAD);
    assign shift_en = serial_valid && (state_q != RX_DONE);

    // Idle abort fires on the cycle the counter would reach the threshold; a
    // strobe in that same cycle resets the counter instead.
    assign timeout_evt = in_frame && !serial_valid &&
                         (idle_q == TO_W'(TIMEOUT_CYCLES - 1));

    nv_bit_deframer u_deframer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .serial_in (serial_in),
        .shift_en  (shift_en),
        .frame_en  (in_frame),
        .frame_rst (!in_frame || timeout_evt),
        .next_word (next_word),
        .byte_done (byte_done)
    );

`ifdef NV_SEQ_RX_ERR_COUNT_EN
    logic [7:0] err_count_q;
    logic [7:0] to_count_q;

    // Diagnostic tallies of error / timeout pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= 8'h00;
            to_count_q  <= 8'h00;
        end else if (clear) begin
            err_count_q <= 8'h00;
            to_count_q  <= 8'h00;
        end else begin
            if (error_q)   err_count_q <= sat_inc8(err_count_q);
            if (timeout_q) to_count_q  <= sat_inc8(to_count_q);
        end
    end

    assign err_count = err_count_q;
    assign to_count  = to_count_q;
`endif

    // Protocol FSM with registered outputs and the idle watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RX_HUNT;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            seq1_count_q <= 8'h00;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            idle_q       <= '0;
        end else if (clear) begin
            state_q      <= RX_HUNT;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            seq1_count_q <= 8'h00;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            idle_q       <= '0;
        end else begin
            byte_valid_q <= 1'b0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                RX_HUNT: begin
                    idle_q <= '0;
                    if (serial_valid && (next_word == SEQ1)) begin
                        state_q      <= RX_SYNCED;
                        seq1_count_q <= 8'd1;
                        byte_out_q   <= SEQ1;
                        byte_valid_q <= 1'b1;
                    end
                end
                RX_SYNCED, RX_PAYLOAD: begin
                    if (byte_done) begin
                        idle_q       <= '0;
                        byte_out_q   <= next_word;
                        byte_valid_q <= 1'b1;
                        if (state_q == RX_SYNCED) begin
                            if (next_word == SEQ1) begin
                                seq1_count_q <= sat_inc8(seq1_count_q);
                            end else if (next_word == SEQ2) begin
                                state_q <= RX_PAYLOAD;
                            end else begin
                                error_q      <= 1'b1;
                                state_q      <= RX_HUNT;
                                seq1_count_q <= 8'h00;
                            end
                        end else if (next_word == SEQ3) begin
                            state_q <= RX_DONE;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= RX_HUNT;
                        end
                    end else if (serial_valid) begin
                        idle_q <= '0;
                    end else if (timeout_evt) begin
                        timeout_q    <= 1'b1;
                        state_q      <= RX_HUNT;
                        seq1_count_q <= 8'h00;
                        idle_q       <= '0;
                    end else begin
                        idle_q <= idle_q + TO_W'(1);
                    end
                end
                default: begin
                    // DONE is sticky; the stream is ignored until clear/reset
                    idle_q <= '0;
                end
            endcase
        end
    end

    assign rx_status  = state_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign seq1_count = seq1_count_q;
    assign error      = error_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_nv_sequence_receiver.sv
// Scoreboard bench for nv_sequence_receiver: directed stimulus pushes the
// expected output event; a monitor pops and compares on every pulse.
module tb_nv_sequence_receiver;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic       serial_valid;
    logic       clear;
    logic [1:0] rx_status;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [7:0] seq1_count;
    logic       error;
    logic       timeout;
`ifdef NV_SEQ_RX_ERR_COUNT_EN
    logic [7:0] err_count;
    logic [7:0] to_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       bv;
        logic [7:0] b;
        logic [1:0] st;
        logic [7:0] s1;
        logic       err;
        logic       to;
    } ev_t;

    ev_t sb[$];

    nv_sequence_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .clear        (clear),
        .rx_status    (rx_status),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .seq1_count   (seq1_count),
        .error        (error),
        .timeout      (timeout)
`ifdef NV_SEQ_RX_ERR_COUNT_EN
        ,
        .err_count    (err_count),
        .to_count     (to_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic bv, input logic [7:0] b, input logic [1:0] st,
                             input logic [7:0] s1, input logic err, input logic to);
        ev_t e;
        e.bv = bv; e.b = b; e.st = st; e.s1 = s1; e.err = err; e.to = to;
        sb.push_back(e);
    endtask

    // Monitor: every pulse on byte_valid/error/timeout must match the queue head
    initial begin
        ev_t act;
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset && (byte_valid || error || timeout)) begin
                act = '{byte_valid, byte_out, rx_status, seq1_count, error, timeout};
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got bv=%0b byte=%h st=%0d s1=%0d err=%0b to=%0b",
                             act.bv, act.b, act.st, act.s1, act.err, act.to);
                end else begin
                    e = sb.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL event: got bv=%0b byte=%h st=%0d s1=%0d err=%0b to=%0b expected bv=%0b byte=%h st=%0d s1=%0d err=%0b to=%0b",
                                 act.bv, act.b, act.st, act.s1, act.err, act.to,
                                 e.bv, e.b, e.st, e.s1, e.err, e.to);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in    = b;
        serial_valid = 1'b1;
        @(posedge clk);
        #1;
        serial_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_status"}, 32'(rx_status), 32'd0);
        chk({tag, "_byte"}, 32'(byte_out), 32'd0);
        chk({tag, "_pulses"}, {29'd0, byte_valid, error, timeout}, 32'd0);
        chk({tag, "_seq1"}, 32'(seq1_count), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        clear        = 1'b0;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        tick(3);
        chk_idle_outputs("reset");
        reset = 1'b0;
        tick(1);

        // SEQ1 from reset
        expect_ev(1, 8'hD7, 2'b01, 8'd1, 0, 0);
        send_byte(8'hD7);
        tick(2);
        chk("seq1_status", 32'(rx_status), 32'd1);

        // Noise then SEQ1 SEQ1 SEQ2 SEQ3
        do_clear();
        send_bit(1'b0);
        send_bit(1'b1);
        expect_ev(1, 8'hD7, 2'b01, 8'd1, 0, 0);
        send_byte(8'hD7);
        expect_ev(1, 8'hD7, 2'b01, 8'd2, 0, 0);
        send_byte(8'hD7);
        expect_ev(1, 8'hA6, 2'b10, 8'd2, 0, 0);
        send_byte(8'hA6);
        expect_ev(1, 8'h29, 2'b11, 8'd2, 0, 0);
        send_byte(8'h29);
        tick(2);

        // Bad byte after SEQ1
        do_clear();
        expect_ev(1, 8'hD7, 2'b01, 8'd1, 0, 0);
        send_byte(8'hD7);
        expect_ev(1, 8'h55, 2'b00, 8'd0, 1, 0);
        send_byte(8'h55);
        tick(2);

        // Idle timeout after SEQ1
        do_clear();
        expect_ev(1, 8'hD7, 2'b01, 8'd1, 0, 0);
        send_byte(8'hD7);
        expect_ev(0, 8'hD7, 2'b00, 8'd0, 0, 1);
        tick(1010);
        chk("timeout_status", 32'(rx_status), 32'd0);

        // Strobe on the threshold cycle suppresses the timeout
        do_clear();
        expect_ev(1, 8'hD7, 2'b01, 8'd1, 0, 0);
        send_byte(8'hD7);
        tick(999);
        send_bit(1'b0);
        tick(5);
        chk("threshold_status", 32'(rx_status), 32'd1);
        chk("threshold_seq1", 32'(seq1_count), 32'd1);

        // DONE is sticky and ignores further bits; clear returns to reset state
        do_clear();
        expect_ev(1, 8'hD7, 2'b01, 8'd1, 0, 0);
        send_byte(8'hD7);
        expect_ev(1, 8'hA6, 2'b10, 8'd1, 0, 0);
        send_byte(8'hA6);
        expect_ev(1, 8'h29, 2'b11, 8'd1, 0, 0);
        send_byte(8'h29);
        send_byte(8'hD7);
        send_byte(8'h55);
        tick(2);
        chk("done_sticky", 32'(rx_status), 32'd3);
        chk("done_byte_hold", 32'(byte_out), 32'h29);
        do_clear();
        chk_idle_outputs("clear");

        // Reset mid-SEQ2, then resync
        expect_ev(1, 8'hD7, 2'b01, 8'd1, 0, 0);
        send_byte(8'hD7);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        #1;
        chk("midreset_status", 32'(rx_status), 32'd0);
        chk("midreset_seq1", 32'(seq1_count), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        expect_ev(1, 8'hD7, 2'b01, 8'd1, 0, 0);
        send_byte(8'hD7);
        tick(2);
        chk("resync_status", 32'(rx_status), 32'd1);

`ifdef NV_SEQ_RX_ERR_COUNT_EN
        // Three bad bytes in a row
        do_clear();
        for (int k = 0; k < 3; k++) begin
            expect_ev(1, 8'hD7, 2'b01, 8'd1, 0, 0);
            send_byte(8'hD7);
            expect_ev(1, 8'h55, 2'b00, 8'd0, 1, 0);
            send_byte(8'h55);
        end
        tick(2);
        chk("err_count", 32'(err_count), 32'd3);
        chk("to_count", 32'(to_count), 32'd0);
`endif

        tick(3);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
